// File: rtl/shared_vc_bank_allocator_pkg.sv
// Shared constants and helpers for the shared VC bank allocator slice.
package shared_vc_bank_allocator_pkg;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_SWITCH = 2'b11
  } fsm_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slot_idx_width_f(input int slots);
    return clog2_min1(slots);
  endfunction

  function automatic int ivc_idx_width_f(input int ports, input int vcs);
    return clog2_min1(ports * vcs);
  endfunction

endpackage

// File: rtl/shared_vc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer that
// moves to winner+1 whenever an update is taken with a live request.
module shared_vc_rr_arbiter #(
  parameter int num_vcs = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [num_vcs-1:0] req,
  input  logic               update,
  output logic [num_vcs-1:0] gnt
);
  import shared_vc_bank_allocator_pkg::*;

  localparam int ptr_w = clog2_min1(num_vcs);

  logic [ptr_w-1:0] ptr;
  logic [ptr_w-1:0] winner;
  logic             found;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < num_vcs; i++) begin
      if (!found && req[(int'(ptr) + i) % num_vcs]) begin
        found = 1'b1;
        gnt[(int'(ptr) + i) % num_vcs] = 1'b1;
        winner = ptr_w'((int'(ptr) + i) % num_vcs);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= ptr_w'((int'(winner) + 1) % num_vcs);
    end
  end

endmodule

// File: rtl/shared_vc_bank_allocator.sv
// Hands the bank's shared VC slots to VCs of the owning port and drains the bank
// on ownership change. Optional drain watchdog: SHARED_VC_DRAIN_WATCHDOG_EN.
module shared_vc_bank_allocator
  import shared_vc_bank_allocator_pkg::*;
#(
  parameter int num_ports        = 5,
  parameter int num_vcs          = 4,
  parameter int num_vcs_per_bank = 2,
  parameter int slot_idx_width   = 1,
  parameter int bank_id          = 0,
  parameter int drain_timeout    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_ports-1:0]           bank_grant_in,
  input  logic                           alloc_enable,
  input  logic [num_ports*num_vcs-1:0]   req_ivc,
  input  logic [num_ports*num_vcs-1:0]   release_ivc,
  output logic [num_ports*num_vcs-1:0]   gnt_ivc,
  output logic [slot_idx_width-1:0]      gnt_slot,
  output logic [num_ports*num_vcs-1:0]   shared_ivc_busy,
  output logic                           bank_busy,
  output logic                           drain_timeout_err
);

  localparam int num_ivcs = num_ports * num_vcs;
  localparam int ivc_w    = ivc_idx_width_f(num_ports, num_vcs);
  localparam int vc_w     = clog2_min1(num_vcs);
  // Ports are numbered from the MSB of the one-hot vector: port p is bit num_ports-1-p.
  localparam logic [num_ports-1:0] reset_owner =
    {{(num_ports-1){1'b0}}, 1'b1} << (num_ports - 1 - bank_id);

  fsm_state_t state, state_next;

  logic [num_ports-1:0]        owner_port;
  logic [num_vcs_per_bank-1:0] slot_valid;
  logic [ivc_w-1:0]            slot_owner [num_vcs_per_bank];

  logic [num_ivcs-1:0]         busy_vec;
  logic [num_ivcs-1:0]         grant_vec;
  logic [num_vcs-1:0]          port_req;
  logic [num_vcs-1:0]          port_busy;
  logic [num_vcs-1:0]          eligible;
  logic [num_vcs-1:0]          win_onehot;
  logic [vc_w-1:0]             win_idx;
  logic [slot_idx_width-1:0]   free_idx;
  logic                        have_free;
  logic                        grant_en;
  logic                        grant_onehot;
  logic                        change_req;
  int                          port_base;

  always_comb begin
    port_base = 0;
    for (int b = 0; b < num_ports; b++) begin
      if (owner_port[b]) port_base = (num_ports - 1 - b) * num_vcs;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int s = 0; s < num_vcs_per_bank; s++) begin
      if (slot_valid[s]) busy_vec[slot_owner[s]] = 1'b1;
    end
  end

  // Lowest-index free slot, from pre-release state so a freed slot waits a cycle.
  always_comb begin
    free_idx  = '0;
    have_free = 1'b0;
    for (int s = num_vcs_per_bank - 1; s >= 0; s--) begin
      if (!slot_valid[s]) begin
        free_idx  = slot_idx_width'(s);
        have_free = 1'b1;
      end
    end
  end

  always_comb begin
    port_req  = req_ivc[port_base +: num_vcs];
    port_busy = busy_vec[port_base +: num_vcs];
    eligible  = port_req & ~port_busy;
    grant_en  = (state == ST_OPEN) && alloc_enable && have_free && (|eligible);
  end

  shared_vc_rr_arbiter #(
    .num_vcs (num_vcs)
  ) u_rr_arbiter (
    .clk    (clk),
    .reset  (reset),
    .req    (eligible),
    .update (grant_en),
    .gnt    (win_onehot)
  );

  always_comb begin
    win_idx   = '0;
    grant_vec = '0;
    for (int v = 0; v < num_vcs; v++) begin
      if (win_onehot[v]) win_idx = vc_w'(v);
    end
    if (grant_en) grant_vec[port_base + int'(win_idx)] = 1'b1;
  end

  always_comb begin
    grant_onehot = (bank_grant_in != '0) &&
                   ((bank_grant_in & (bank_grant_in - 1'b1)) == '0);
    change_req   = grant_onehot && (bank_grant_in != owner_port);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_OPEN:   if (change_req) state_next = bank_busy ? ST_DRAIN : ST_SWITCH;
      ST_DRAIN:  if (!bank_busy) state_next = ST_SWITCH;
      ST_SWITCH: state_next = ST_OPEN;
      default:   state_next = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_OPEN;
    else       state <= state_next;
  end

  // A released slot and the granted slot never coincide: grants take only free slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      for (int s = 0; s < num_vcs_per_bank; s++) slot_owner[s] <= '0;
      gnt_ivc    <= '0;
      gnt_slot   <= '0;
      owner_port <= reset_owner;
    end else begin
      for (int s = 0; s < num_vcs_per_bank; s++) begin
        if (slot_valid[s] && release_ivc[slot_owner[s]]) slot_valid[s] <= 1'b0;
      end
      gnt_ivc  <= grant_vec;
      gnt_slot <= grant_en ? free_idx : '0;
      if (grant_en) begin
        slot_valid[free_idx] <= 1'b1;
        slot_owner[free_idx] <= ivc_w'(port_base + int'(win_idx));
      end
      if (state == ST_SWITCH && grant_onehot) owner_port <= bank_grant_in;
    end
  end

  assign shared_ivc_busy = busy_vec;
  assign bank_busy       = |slot_valid;

`ifdef SHARED_VC_DRAIN_WATCHDOG_EN
  localparam int wd_w = clog2_min1(drain_timeout + 1);

  logic [wd_w-1:0] wd_count;
  logic            wd_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= '0;
      wd_err   <= 1'b0;
    end else if (state == ST_DRAIN) begin
      if (wd_count != wd_w'(drain_timeout)) wd_count <= wd_count + 1'b1;
      if (wd_count == wd_w'(drain_timeout - 1)) wd_err <= 1'b1;
    end else begin
      wd_count <= '0;
    end
  end

  assign drain_timeout_err = wd_err;
`else
  logic unused_drain_cfg;
  assign unused_drain_cfg  = (drain_timeout != 0);
  assign drain_timeout_err = 1'b0;
`endif

endmodule
